tc_fetch_sequencer: RTL and testbench

TC_FETCH_SEQUENCER -- requirements
Module: tc_fetch_sequencer

---
 rtl/tc_fetch_pkg.sv | 23 ++
 rtl/tc_fetch_holdreg.sv | 58 +++++
 rtl/tc_fetch_sequencer.sv | 109 ++++++++++
 tb/tb_tc_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_fetch_pkg.sv
// Shared definitions for the fetch sequencer: sequencer states, the width of
// the length field carried in the first program word, and the length decode.
package tc_fetch_pkg;

    // Width of program addresses and of the instruction length output
    localparam int ADDR_W      = 16;
    localparam int LEN_W       = 3;

    // The length field in word0 encodes (word count - 1) in two bits
    localparam int LEN_FIELD_W = 2;

    // Sequencer states: actively fetching, or parked until a redirect
    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Turn the raw two-bit length field into a word count of 1..4
    function automatic logic [LEN_W-1:0] decode_len(input logic [LEN_FIELD_W-1:0] field);
        return {1'b0, field} + 3'd1;
    endfunction

endpackage

// File: rtl/tc_fetch_holdreg.sv
// Instruction holding register. It captures one instruction (up to four
// words plus its length and address) and keeps it until the consumer takes
// it. A flush throws the held instruction away without reloading.
module tc_fetch_holdreg
    import tc_fetch_pkg::*;
#(
    parameter int                BIT_WIDTH  = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 flush,
    input  logic                 consume,
    input  logic [BIT_WIDTH-1:0] word0,
    input  logic [BIT_WIDTH-1:0] word1,
    input  logic [BIT_WIDTH-1:0] word2,
    input  logic [BIT_WIDTH-1:0] word3,
    input  logic [LEN_W-1:0]     len_in,
    input  logic [ADDR_W-1:0]    pc_in,
    output logic [BIT_WIDTH-1:0] instr0,
    output logic [BIT_WIDTH-1:0] instr1,
    output logic [BIT_WIDTH-1:0] instr2,
    output logic [BIT_WIDTH-1:0] instr3,
    output logic [LEN_W-1:0]     instr_len,
    output logic [ADDR_W-1:0]    instr_pc,
    output logic                 instr_valid
);

    // Reset empties the register; a flush beats a load so a redirect never
    // lets a stale fetch through; a load overwrites even a just-consumed
    // entry, which is what gives back-to-back delivery; a bare consume
    // simply empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr0      <= '0;
            instr1      <= '0;
            instr2      <= '0;
            instr3      <= '0;
            instr_len   <= 3'd1;
            instr_pc    <= RESET_ADDR;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr0      <= word0;
            instr1      <= word1;
            instr2      <= word2;
            instr3      <= word3;
            instr_len   <= len_in;
            instr_pc    <= pc_in;
            instr_valid <= 1'b1;
        end else if (consume) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tc_fetch_sequencer.sv
// Fetch sequencer. It walks a program counter through a word-addressed
// memory, decodes each instruction's length from its first word and hands
// whole instructions to a consumer through a single holding register.
// Redirects (jumps) and a halt request steer the walk.
module tc_fetch_sequencer
    import tc_fetch_pkg::*;
#(
    parameter int                BIT_WIDTH  = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000,
    parameter int                LEN_LSB    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_W-1:0]    address,
    input  logic [BIT_WIDTH-1:0] word0,
    input  logic [BIT_WIDTH-1:0] word1,
    input  logic [BIT_WIDTH-1:0] word2,
    input  logic [BIT_WIDTH-1:0] word3,
    input  logic                 instr_ready,
    input  logic                 jump_valid,
    input  logic [ADDR_W-1:0]    jump_target,
    input  logic                 halt_req,
    output logic [BIT_WIDTH-1:0] instr0,
    output logic [BIT_WIDTH-1:0] instr1,
    output logic [BIT_WIDTH-1:0] instr2,
    output logic [BIT_WIDTH-1:0] instr3,
    output logic [LEN_W-1:0]     instr_len,
    output logic [ADDR_W-1:0]    instr_pc,
    output logic                 instr_valid,
    output logic                 halted
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [LEN_W-1:0]  len;
    logic              load;

    assign len     = decode_len(word0[LEN_LSB +: LEN_FIELD_W]);
    assign address = pc;
    assign halted  = (state == HALTED);

    // State and program counter registers; reset overrides jump and halt
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_ADDR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next state, next PC and load decision; a jump wins over everything,
    // a halt request suppresses the load in the cycle it is seen, and a
    // load happens whenever the holding register is empty or being drained
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        if (jump_valid) begin
            state_next = FETCH;
            pc_next    = jump_target;
        end else begin
            case (state)
                FETCH: begin
                    if (halt_req) begin
                        state_next = HALTED;
                    end else if (!instr_valid || instr_ready) begin
                        load    = 1'b1;
                        pc_next = pc + {{(ADDR_W-LEN_W){1'b0}}, len};
                    end
                end
                HALTED: begin
                    state_next = HALTED;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    tc_fetch_holdreg #(
        .BIT_WIDTH  (BIT_WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_holdreg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (jump_valid),
        .consume     (instr_ready),
        .word0       (word0),
        .word1       (word1),
        .word2       (word2),
        .word3       (word3),
        .len_in      (len),
        .pc_in       (pc),
        .instr0      (instr0),
        .instr1      (instr1),
        .instr2      (instr2),
        .instr3      (instr3),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// Testbench for tc_fetch_sequencer: directed scenarios followed by random
// traffic, with a behavioural program-flow model feeding a scoreboard.
module tb_tc_fetch_sequencer;

    localparam int          BW       = 16;
    localparam logic [15:0] RST_ADDR = 16'h0000;
    localparam int          LSB      = 0;

    typedef struct packed {
        logic [15:0]   pc;
        logic [2:0]    len;
        logic [BW-1:0] w0;
        logic [BW-1:0] w1;
        logic [BW-1:0] w2;
        logic [BW-1:0] w3;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   address;
    logic [BW-1:0] word0, word1, word2, word3;
    logic          instr_ready;
    logic          jump_valid;
    logic [15:0]   jump_target;
    logic          halt_req;
    logic [BW-1:0] instr0, instr1, instr2, instr3;
    logic [2:0]    instr_len;
    logic [15:0]   instr_pc;
    logic          instr_valid;
    logic          halted;

    logic [BW-1:0] mem [0:65535];
    logic [15:0]   a1, a2, a3;

    // Reference model: next fetch address, halted flag, held instruction
    logic [15:0]   m_pc;
    logic          m_halted;
    logic          m_valid;
    instr_t        m_held;

    instr_t        expq [$];
    logic [15:0]   log_pc [$];
    int            log_len [$];

    int checks = 0;
    int passed = 0;

    tc_fetch_sequencer #(
        .BIT_WIDTH  (BW),
        .RESET_ADDR (RST_ADDR),
        .LEN_LSB    (LSB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .word0       (word0),
        .word1       (word1),
        .word2       (word2),
        .word3       (word3),
        .instr_ready (instr_ready),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .halt_req    (halt_req),
        .instr0      (instr0),
        .instr1      (instr1),
        .instr2      (instr2),
        .instr3      (instr3),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign a1    = address + 16'd1;
    assign a2    = address + 16'd2;
    assign a3    = address + 16'd3;
    assign word0 = mem[address];
    assign word1 = mem[a1];
    assign word2 = mem[a2];
    assign word3 = mem[a3];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic instr_t fetchAt(input logic [15:0] a);
        instr_t      t;
        logic [15:0] b;
        int          field;
        field  = int'(mem[a] >> LSB) & 3;
        t.pc   = a;
        t.len  = 3'(field + 1);
        t.w0   = mem[a];
        b      = a + 16'd1;
        t.w1   = mem[b];
        b      = a + 16'd2;
        t.w2   = mem[b];
        b      = a + 16'd3;
        t.w3   = mem[b];
        return t;
    endfunction

    task automatic setLen(input logic [15:0] a, input int n);
        logic [BW-1:0] mask;
        mask   = BW'(3) << LSB;
        mem[a] = (mem[a] & ~mask) | (BW'(n - 1) << LSB);
    endtask

    // Per-cycle architectural checks against the model
    task automatic checkOutput();
        checkVal("address", address, m_pc);
        checkVal("instr_valid", instr_valid, m_valid);
        checkVal("halted", halted, m_halted);
        if (m_valid) begin
            checkVal("held_pc", instr_pc, m_held.pc);
            checkVal("held_len", instr_len, m_held.len);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic applyStimulus(input logic r, input logic rdy, input logic j,
                                 input logic [15:0] tgt, input logic h);
        rst         = r;
        instr_ready = rdy;
        jump_valid  = j;
        jump_target = tgt;
        halt_req    = h;
        if (!r && m_valid && rdy) expq.push_back(m_held);
        if (r) begin
            m_pc = RST_ADDR; m_halted = 1'b0; m_valid = 1'b0;
        end else if (j) begin
            m_pc = tgt; m_halted = 1'b0; m_valid = 1'b0;
        end else if (m_halted) begin
            if (rdy) m_valid = 1'b0;
        end else if (h) begin
            m_halted = 1'b1;
            if (rdy) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_held  = fetchAt(m_pc);
            m_valid = 1'b1;
            m_pc    = 16'((int'(m_pc) + int'(m_held.len)) % 65536);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Monitor: every accepted instruction is matched against the scoreboard
    always @(negedge clk) begin
        instr_t e;
        if (instr_valid && instr_ready && !rst) begin
            if (expq.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_transfer: got pc %0h, expected none", instr_pc);
            end else begin
                e = expq.pop_front();
                checkVal("xfer_pc", instr_pc, e.pc);
                checkVal("xfer_len", instr_len, e.len);
                checkVal("xfer_w0", instr0, e.w0);
                checkVal("xfer_w1", instr1, e.w1);
                checkVal("xfer_w2", instr2, e.w2);
                checkVal("xfer_w3", instr3, e.w3);
            end
            log_pc.push_back(instr_pc);
            log_len.push_back(int'(instr_len));
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = BW'($urandom);
        setLen(16'h0000, 1);
        setLen(16'h0001, 2);
        setLen(16'h0003, 4);
        setLen(16'hFFFE, 4);
        m_pc = RST_ADDR; m_halted = 1'b0; m_valid = 1'b0; m_held = '0;

        // Reset and straight-line delivery of lengths 1, 2, 4
        applyStimulus(1, 0, 0, 16'h0, 0);
        applyStimulus(1, 0, 0, 16'h0, 0);
        checkVal("rst_instr0", instr0, 0);
        checkVal("rst_instr3", instr3, 0);
        checkVal("rst_len", instr_len, 1);
        checkVal("rst_pc", instr_pc, RST_ADDR);
        log_pc.delete(); log_len.delete();
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'h0, 0);
        checkVal("seq_count", log_pc.size(), 3);
        checkVal("seq_pc0", log_pc[0], 16'h0000);
        checkVal("seq_pc1", log_pc[1], 16'h0001);
        checkVal("seq_pc2", log_pc[2], 16'h0003);
        checkVal("seq_len0", log_len[0], 1);
        checkVal("seq_len1", log_len[1], 2);
        checkVal("seq_len2", log_len[2], 4);

        // Back-pressure hold at 0x0005
        applyStimulus(0, 0, 1, 16'h0005, 0);
        applyStimulus(0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 16'h0, 0);
            checkVal("hold_pc", instr_pc, 16'h0005);
        end
        applyStimulus(0, 1, 0, 16'h0, 0);
        applyStimulus(0, 1, 0, 16'h0, 0);

        // Jump discards a held instruction at 0x0010
        applyStimulus(0, 0, 1, 16'h0010, 0);
        applyStimulus(0, 0, 0, 16'h0, 0);
        applyStimulus(0, 0, 1, 16'h0040, 0);
        checkVal("jmp_valid_drop", instr_valid, 0);
        checkVal("jmp_address", address, 16'h0040);
        applyStimulus(0, 0, 0, 16'h0, 0);
        checkVal("jmp_valid_new", instr_valid, 1);
        checkVal("jmp_pc_new", instr_pc, 16'h0040);
        applyStimulus(0, 1, 0, 16'h0, 0);

        // PC wrap from 0xFFFE with a four-word instruction
        applyStimulus(0, 1, 1, 16'hFFFE, 0);
        log_pc.delete(); log_len.delete();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 16'h0, 0);
        checkVal("wrap_first", log_pc[0], 16'hFFFE);
        checkVal("wrap_next", log_pc[1], 16'h0002);

        // Halt with an instruction held at 0x0020, then resume by jump
        applyStimulus(0, 0, 1, 16'h0020, 0);
        applyStimulus(0, 0, 0, 16'h0, 0);
        applyStimulus(0, 0, 0, 16'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 0);
        log_pc.delete(); log_len.delete();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 16'h0, 0);
        checkVal("halt_delivered", log_pc.size(), 1);
        checkVal("halt_pc", log_pc[0], 16'h0020);
        checkVal("halt_flag", halted, 1);
        checkVal("halt_no_valid", instr_valid, 0);
        applyStimulus(0, 1, 1, 16'h0000, 0);
        checkVal("resume_halted", halted, 0);
        applyStimulus(0, 1, 0, 16'h0, 0);
        applyStimulus(0, 1, 0, 16'h0, 0);

        // Reset pulse during a back-pressure hold
        applyStimulus(0, 0, 0, 16'h0, 0);
        applyStimulus(0, 0, 0, 16'h0, 0);
        applyStimulus(1, 0, 0, 16'h0, 0);
        checkVal("rstmid_valid", instr_valid, 0);
        checkVal("rstmid_address", address, RST_ADDR);
        applyStimulus(0, 1, 0, 16'h0, 0);
        applyStimulus(0, 1, 0, 16'h0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, j, h, rdy;
            logic [15:0] tgt;
            r   = ($urandom_range(99) == 0);
            j   = ($urandom_range(99) < 5);
            h   = ($urandom_range(99) < 5);
            rdy = ($urandom_range(99) < 70);
            tgt = ($urandom_range(3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(7)))
                                           : 16'($urandom);
            applyStimulus(r, rdy, j, tgt, h);
        end
        applyStimulus(0, 0, 0, 16'h0, 0);
        checkVal("scoreboard_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
